mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_rr.sv | 20 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// owner codes, reused by the control logic and the testbench.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;

  // One-hot grant {ldr, cpu} to the owner code reported on the owner port.
  function automatic logic [1:0] owner_code(input logic [1:0] gnt);
    case (gnt)
      2'b01:   return OWN_CPU;
      2'b10:   return OWN_LDR;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin grant: on a tie the requester not served last wins.
// Request/grant bit 0 is the CPU, bit 1 the loader.
module mem_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_ldr_i,
  output logic [1:0] gnt_o
);

  // Combinational one-hot grant selection.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_ldr_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU and a program-loader requester onto one memory port,
// with a bounded wait for mem_ready and fully registered outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic [15:0] ldr_rdata,
  output logic        ldr_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err,
  output logic [1:0]  owner
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  arb_state_e  state_q;
  logic        sel_ldr_q;
  logic        last_ldr_q;
  logic [7:0]  tmo_cnt_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] cpu_rdata_q;
  logic [15:0] ldr_rdata_q;
  logic        cpu_ack_q;
  logic        ldr_ack_q;
  logic        err_q;
  logic [1:0]  owner_q;

  logic [1:0]  req_s;
  logic [1:0]  gnt_s;
  logic        done_s;
  logic [15:0] rdata_d;

  assign req_s   = {ldr_req, cpu_req};
  assign done_s  = mem_ready || (tmo_cnt_q == TIMEOUT_C);
  assign rdata_d = mem_ready ? mem_rdata : 16'h0000;

  mem_arb_rr u_rr (
    .req_i      (req_s),
    .last_ldr_i (last_ldr_q),
    .gnt_o      (gnt_s)
  );

  // Arbiter FSM; every output is a register written here.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      sel_ldr_q   <= 1'b0;
      last_ldr_q  <= 1'b1;
      tmo_cnt_q   <= 8'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      ldr_rdata_q <= 16'h0000;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      owner_q     <= OWN_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cpu_ack_q <= 1'b0;
          ldr_ack_q <= 1'b0;
          err_q     <= 1'b0;
          if (gnt_s != 2'b00) begin
            state_q     <= ST_ACCESS;
            sel_ldr_q   <= gnt_s[1];
            last_ldr_q  <= gnt_s[1];
            owner_q     <= owner_code(gnt_s);
            tmo_cnt_q   <= 8'd1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= gnt_s[1] ? ldr_we    : cpu_we;
            mem_addr_q  <= gnt_s[1] ? ldr_addr  : cpu_addr;
            mem_wdata_q <= gnt_s[1] ? ldr_wdata : cpu_wdata;
          end else begin
            owner_q   <= OWN_NONE;
            tmo_cnt_q <= 8'd0;
          end
        end
        ST_ACCESS: begin
          // mem_ready wins over a timeout landing on the same cycle.
          if (done_s) begin
            state_q     <= ST_RESP;
            tmo_cnt_q   <= 8'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            err_q       <= !mem_ready;
            if (sel_ldr_q) begin
              ldr_ack_q   <= 1'b1;
              ldr_rdata_q <= rdata_d;
            end else begin
              cpu_ack_q   <= 1'b1;
              cpu_rdata_q <= rdata_d;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          cpu_ack_q <= 1'b0;
          ldr_ack_q <= 1'b0;
          err_q     <= 1'b0;
          owner_q   <= OWN_NONE;
        end
        default: begin
          state_q   <= ST_IDLE;
          tmo_cnt_q <= 8'd0;
          mem_en_q  <= 1'b0;
          cpu_ack_q <= 1'b0;
          ldr_ack_q <= 1'b0;
          err_q     <= 1'b0;
          owner_q   <= OWN_NONE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign err       = err_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand sequences,
// with a scoreboard of expected accesses consumed by an output monitor.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TMO = 15;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000, cpu_wdata = 16'h0000;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [15:0] ldr_addr = 16'h0000, ldr_wdata = 16'h0000;
  logic [15:0] ldr_rdata;
  logic        ldr_ack;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ready = 1'b0;
  logic        err;
  logic [1:0]  owner;

  mem_port_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .owner(owner)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic        ldr;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ready_at;
    logic [15:0] mem_data;
    logic        stray;
    logic        drop;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_en;
  } vec_t;

  typedef struct {
    logic        ldr;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          en;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int          n_chk = 0, n_fail = 0, ack_seen = 0, en_run = 0;
  int          acc_cyc = 0, ready_at = 0;
  logic        stray = 1'b0;
  logic        last_ldr_m = 1'b1;
  logic [15:0] cpu_rd_m = 16'h0000, ldr_rd_m = 16'h0000;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk_exp(input logic l, input logic w, input logic [15:0] a,
                                  input logic [15:0] wd, input logic [15:0] rd,
                                  input logic e, input int n);
    exp_t x;
    x.ldr = l; x.we = w; x.addr = a; x.wdata = wd; x.rdata = rd; x.err = e; x.en = n;
    return x;
  endfunction

  // Memory model: mem_ready in the ready_at-th ACCESS cycle; optional stray ready outside ACCESS.
  initial forever begin
    @(negedge CLK);
    if (mem_en) begin
      acc_cyc++;
      mem_ready = (acc_cyc == ready_at);
    end else begin
      acc_cyc = 0;
      mem_ready = stray;
    end
  end

  // Output monitor: checks memory-side drive and consumes scoreboard entries on ack.
  initial forever begin
    exp_t it;
    @(negedge CLK);
    if (!Reset) begin
      en_run = 0;
    end else begin
      if (mem_en) begin
        en_run++;
        if (sb.size() == 0) chk("mem_en_unexpected", 32'(mem_en), 32'd0);
        else begin
          it = sb[0];
          chk("mem_we", 32'(mem_we), 32'(it.we));
          chk("mem_addr", 32'(mem_addr), 32'(it.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(it.wdata));
          chk("owner_access", 32'(owner), 32'(it.ldr ? OWN_LDR : OWN_CPU));
        end
      end
      if (cpu_ack || ldr_ack) begin
        if (sb.size() == 0) chk("ack_unexpected", 32'({ldr_ack, cpu_ack}), 32'd0);
        else begin
          it = sb.pop_front();
          chk("ack_who", 32'({ldr_ack, cpu_ack}), it.ldr ? 32'd2 : 32'd1);
          chk("ack_err", 32'(err), 32'(it.err));
          chk("mem_en_cycles", en_run, it.en);
          chk("mem_en_in_resp", 32'(mem_en), 32'd0);
          chk("owner_resp", 32'(owner), 32'(it.ldr ? OWN_LDR : OWN_CPU));
          if (it.ldr) begin
            chk("ldr_rdata", 32'(ldr_rdata), 32'(it.rdata));
            chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(cpu_rd_m));
            ldr_rd_m = it.rdata;
          end else begin
            chk("cpu_rdata", 32'(cpu_rdata), 32'(it.rdata));
            chk("ldr_rdata_hold", 32'(ldr_rdata), 32'(ldr_rd_m));
            cpu_rd_m = it.rdata;
          end
        end
        en_run = 0;
        ack_seen++;
      end else if (err) begin
        chk("err_without_ack", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic drive_req(input logic l, input logic v, input logic w,
                           input logic [15:0] a, input logic [15:0] wd);
    if (l) begin
      ldr_req = v; ldr_we = w; ldr_addr = a; ldr_wdata = wd;
    end else begin
      cpu_req = v; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_ldr_ack"}, 32'(ldr_ack), 32'd0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    chk({tag, "_ldr_rdata"}, 32'(ldr_rdata), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'(OWN_NONE));
  endtask

  task automatic wait_ack(input string name);
    int base = ack_seen;
    int n = 0;
    while (ack_seen == base && n < 60) begin
      @(negedge CLK); #1; n++;
    end
    chk(name, ack_seen - base, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int base, lat;
    @(posedge CLK); #1;
    ready_at = v.ready_at; mem_rdata = v.mem_data; stray = v.stray;
    sb.push_back(mk_exp(v.ldr, v.we, v.addr, v.wdata, v.exp_rdata, v.exp_err, v.exp_en));
    drive_req(v.ldr, 1'b1, v.we, v.addr, v.wdata);
    base = ack_seen; lat = 0;
    while (ack_seen == base && lat < 60) begin
      @(negedge CLK); #1; lat++;
      if (v.drop && lat == 2) drive_req(v.ldr, 1'b0, v.we, v.addr, v.wdata);
    end
    chk("vec_ack_arrived", ack_seen - base, 1);
    chk("vec_latency", lat, v.exp_en + 2);
    last_ldr_m = v.ldr;
    @(posedge CLK); #1;
    drive_req(v.ldr, 1'b0, v.we, v.addr, v.wdata);
    stray = 1'b0;
  endtask

  initial begin
    logic [1:0] own_exp[6];
    exp_t c_it, l_it;
    int base, saved;

    //          ldr   we    addr      wdata     rdy mem_data  stray drop  exp_rd    err   en
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1,  16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 16'h0100, 16'h1234, 5,  16'h7777, 1'b0, 1'b0, 16'h7777, 1'b0, 5};
    vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 2,  16'h1111, 1'b0, 1'b0, 16'h1111, 1'b0, 2};
    vecs[3] = '{1'b1, 1'b0, 16'hABCD, 16'h0000, 15, 16'hC0DE, 1'b0, 1'b0, 16'hC0DE, 1'b0, 15};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 0,  16'h9999, 1'b0, 1'b0, 16'h0000, 1'b1, 15};
    vecs[5] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16, 16'h6666, 1'b0, 1'b0, 16'h0000, 1'b1, 15};
    vecs[6] = '{1'b0, 1'b0, 16'h4242, 16'h0000, 3,  16'h4242, 1'b1, 1'b0, 16'h4242, 1'b0, 3};
    vecs[7] = '{1'b0, 1'b1, 16'h0001, 16'hFFFF, 3,  16'h0F0F, 1'b0, 1'b1, 16'h0F0F, 1'b0, 3};

    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    Reset = 1'b1;

    // Simultaneous requests out of reset: CPU first, loader in the next grant.
    @(posedge CLK); #1;
    ready_at = 1; mem_rdata = 16'h0C0C;
    sb.push_back(mk_exp(1'b0, 1'b0, 16'h0020, 16'h0055, 16'h0C0C, 1'b0, 1));
    sb.push_back(mk_exp(1'b1, 1'b1, 16'h0030, 16'h00AA, 16'h0C0C, 1'b0, 1));
    own_exp = '{OWN_NONE, OWN_CPU, OWN_CPU, OWN_NONE, OWN_LDR, OWN_LDR};
    base = ack_seen;
    drive_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0055);
    drive_req(1'b1, 1'b1, 1'b1, 16'h0030, 16'h00AA);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("tie_owner_seq", 32'(owner), 32'(own_exp[i]));
      if (i == 2) cpu_req = 1'b0;
    end
    #1;
    chk("tie_two_acks", ack_seen - base, 2);
    @(posedge CLK); #1;
    ldr_req = 1'b0;
    last_ldr_m = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Second tie: whoever was not served last must win.
    @(posedge CLK); #1;
    ready_at = 1; mem_rdata = 16'h3C3C;
    c_it = mk_exp(1'b0, 1'b0, 16'h2222, 16'h0000, 16'h3C3C, 1'b0, 1);
    l_it = mk_exp(1'b1, 1'b0, 16'h3333, 16'h0000, 16'h3C3C, 1'b0, 1);
    if (last_ldr_m) begin
      sb.push_back(c_it); sb.push_back(l_it);
    end else begin
      sb.push_back(l_it); sb.push_back(c_it);
    end
    drive_req(1'b0, 1'b1, 1'b0, 16'h2222, 16'h0000);
    drive_req(1'b1, 1'b1, 1'b0, 16'h3333, 16'h0000);
    wait_ack("rr_first_ack");
    @(posedge CLK); #1;
    if (last_ldr_m) cpu_req = 1'b0; else ldr_req = 1'b0;
    wait_ack("rr_second_ack");
    @(posedge CLK); #1;
    cpu_req = 1'b0; ldr_req = 1'b0;

    // Reset during the second ACCESS cycle, then the held CPU request is served.
    @(posedge CLK); #1;
    ready_at = 0; mem_rdata = 16'h5151;
    sb.push_back(mk_exp(1'b0, 1'b0, 16'h0777, 16'h0042, 16'h5151, 1'b0, 1));
    drive_req(1'b0, 1'b1, 1'b0, 16'h0777, 16'h0042);
    repeat (3) @(negedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    cpu_rd_m = 16'h0000; ldr_rd_m = 16'h0000;
    saved = ack_seen;
    repeat (2) @(negedge CLK);
    #1;
    chk("no_ack_in_reset", ack_seen - saved, 0);
    ready_at = 1;
    sb.push_back(mk_exp(1'b0, 1'b0, 16'h0777, 16'h0042, 16'h5151, 1'b0, 1));
    Reset = 1'b1;
    wait_ack("post_reset_ack");
    @(posedge CLK); #1;
    cpu_req = 1'b0;

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_owner_idle", 32'(owner), 32'(OWN_NONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
